dmem_responder: RTL and testbench

Data-memory target that answers the load/store requests issued by the core's MEM stage over a valid/ready request channel and a valid/ready response channel. It holds word-organised storage, commits byte-enabled stores, and returns load data after a fixed, parameterised latency. It sits on the memory side of the core-to-memory boundary as the responder to the core's data-access initiator. Only one transaction is outstanding at a time, so ordering is trivially preserved.

---
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Core-to-data-memory request/response channel: valid/ready request with byte
// enables, valid/ready response carrying load data and an error flag.
interface dmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory answering one load/store at a time with a fixed
// accept-to-response latency; byte-enabled stores, error flag on illegal access.
module dmem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input logic  clk,
  input logic  rst,
  dmem_if.slave bus
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 3;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH_WORDS];

  logic                   accept;
  logic                   req_bad;
  logic                   wr_en;
  logic [IDX_W-1:0]       widx;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign widx          = bus.req_addr[IDX_W+1:2];
  assign req_bad       = (bus.req_addr[1:0] != 2'b00) || (bus.req_be == '0) ||
                         ({1'b0, bus.req_addr} >= ADDR_LIMIT);
  assign wr_en         = accept && bus.req_we && !req_bad;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Load data is captured now and held until the handshake.
          rsp_err_d   = req_bad;
          rsp_rdata_d = (!bus.req_we && !req_bad) ? mem_q[widx] : '0;
          if (READ_LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(READ_LATENCY - 2);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is not reset; req_ready is low during rst so no write can slip in.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) mem_q[widx][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a latency-2 instance, plus
// back-pressure, reset-in-flight and a latency sweep over latency 1/2/4 instances.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_vld;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rsp_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
  dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();
  dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if4 ();

  assign if1.req_valid = req_vld[0];
  assign if2.req_valid = req_vld[1];
  assign if4.req_valid = req_vld[2];
  assign if1.req_we = we;    assign if2.req_we = we;    assign if4.req_we = we;
  assign if1.req_addr = addr; assign if2.req_addr = addr; assign if4.req_addr = addr;
  assign if1.req_wdata = wdata; assign if2.req_wdata = wdata; assign if4.req_wdata = wdata;
  assign if1.req_be = be;    assign if2.req_be = be;    assign if4.req_be = be;
  assign if1.rsp_ready = rsp_ready;
  assign if2.rsp_ready = rsp_ready;
  assign if4.rsp_ready = rsp_ready;

  dmem_responder #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  dmem_responder #(.READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  dmem_responder #(.READ_LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [2:0] rdy_v, rv_v;
  assign rdy_v = {if4.req_ready, if2.req_ready, if1.req_ready};
  assign rv_v  = {if4.rsp_valid, if2.rsp_valid, if1.rsp_valid};

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // One transaction on the latency-2 instance with rsp_ready held high.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic er,
                     output int lat);
    int k;
    we = w; addr = a; wdata = d; be = b; rsp_ready = 1'b1; req_vld = 3'b010;
    k = 0;
    @(negedge clk);
    while (!if2.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) timeout_fail("accept");
    @(posedge clk);
    #1 req_vld = 3'b000;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if2.rsp_valid && lat < 20);
    if (!if2.rsp_valid) timeout_fail("rsp_valid");
    rd = if2.rsp_rdata;
    er = if2.rsp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          k;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,   32'h0000AA00, 4'h2, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 32'h1122AA44, 1'b0};
    vecs[5]  = '{1'b0, 32'h13,   32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'h10,   32'h77777777, 4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFC,  32'h0BADCAFE, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'hFFC,  32'h0,        4'h1, 32'h0BADCAFE, 1'b0};
    vecs[11] = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h0,        1'b1};
    vecs[12] = '{1'b1, 32'h20,   32'hA5A5A5A5, 4'h9, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h20,   32'h0,        4'hF, 32'hA522AAA5, 1'b0};

    rst = 1'b1; req_vld = 3'b000; we = 1'b0; addr = '0; wdata = '0; be = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'b0, if2.req_ready}, 32'd0);
    chk("reset rsp_valid", {31'b0, if2.rsp_valid}, 32'd0);
    chk("reset rsp_rdata", if2.rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'b0, if2.rsp_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", {31'b0, if2.req_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d latency", i), lat, 32'd2);
    end

    // Back-pressure: load held unacknowledged for 5 cycles.
    we = 1'b0; addr = 32'h20; wdata = '0; be = 4'hF; rsp_ready = 1'b0; req_vld = 3'b010;
    k = 0;
    @(negedge clk);
    while (!if2.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) timeout_fail("bp accept");
    @(posedge clk);
    #1 req_vld = 3'b000;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if2.rsp_valid && lat < 20);
    chk("bp latency", lat, 32'd2);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d rsp_valid", c), {31'b0, if2.rsp_valid}, 32'd1);
      chk($sformatf("bp%0d rsp_rdata", c), if2.rsp_rdata, 32'hA522AAA5);
      chk($sformatf("bp%0d rsp_err", c), {31'b0, if2.rsp_err}, 32'd0);
      chk($sformatf("bp%0d req_ready", c), {31'b0, if2.req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp still valid", {31'b0, if2.rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release req_ready", {31'b0, if2.req_ready}, 32'd1);
    chk("bp release rsp_valid", {31'b0, if2.rsp_valid}, 32'd0);
    chk("bp release rsp_rdata", if2.rsp_rdata, 32'd0);

    // Reset while BUSY with a store in flight.
    @(posedge clk);
    #1;
    we = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; be = 4'hF; rsp_ready = 1'b1;
    req_vld = 3'b010;
    @(negedge clk);
    chk("rm req_ready", {31'b0, if2.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_vld = 3'b000;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rm rsp_valid", {31'b0, if2.rsp_valid}, 32'd0);
    chk("rm rsp_rdata", if2.rsp_rdata, 32'd0);
    chk("rm rsp_err", {31'b0, if2.rsp_err}, 32'd0);
    chk("rm req_ready in rst", {31'b0, if2.req_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rm quiet%0d", c), {31'b0, if2.rsp_valid}, 32'd0);
    end
    txn(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat);
    chk("rm load rdata", rd, 32'hCAFEF00D);
    chk("rm load err", {31'b0, er}, 32'd0);

    // Latency sweep with request held valid and rsp_ready tied high.
    for (int d = 0; d < 3; d++) begin
      int lat_exp;
      int a0, a1, v0;
      lat_exp = (d == 0) ? 1 : (d == 1) ? 2 : 4;
      a0 = -1; a1 = -1; v0 = -1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h0; be = 4'hF;
      req_vld = 3'b001 << d;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (rdy_v[d]) begin
          if (a0 < 0) a0 = c;
          else if (a1 < 0) a1 = c;
        end
        if (rv_v[d] && v0 < 0) v0 = c;
      end
      @(posedge clk);
      #1 req_vld = 3'b000;
      repeat (6) @(posedge clk);
      #1;
      chk($sformatf("sweep L%0d latency", lat_exp), v0 - a0, lat_exp);
      chk($sformatf("sweep L%0d spacing", lat_exp), a1 - a0, lat_exp + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
